// File: rtl/axi_register_slice.sv
// axi_register_slice
// Full-throughput AXI4 register slice. Every channel (AW, W, B, AR, R) is a
// two-entry skid buffer. Each beat takes one cycle to pass through, one beat
// per cycle is sustained, and no output depends combinationally on any input.
// Optional build macro: AXI_REGISTER_SLICE_RESP_BYPASS_EN. When it is defined,
// the B and R channels become pure wires with zero latency. AW, W and AR stay
// registered.

// One channel slice: an output register plus a skid register.
module axi_register_slice_stage #(
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] up_payload,
    input  logic             up_valid,
    output logic             up_ready,
    output logic [Width-1:0] dn_payload,
    output logic             dn_valid,
    input  logic             dn_ready
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               out_valid_r;
    logic               up_ready_r;
    logic [Width-1:0]   out_payload_r;
    logic [Width-1:0]   skid_payload_r;
    logic               in_s;
    logic               out_s;
    logic               load_out_in_s;
    logic               load_out_skid_s;
    logic               load_skid_s;

    assign in_s       = up_valid & up_ready_r;
    assign out_s      = out_valid_r & dn_ready;
    assign up_ready   = up_ready_r;
    assign dn_valid   = out_valid_r;
    assign dn_payload = out_payload_r;

    // State register; valid and ready flags are registered copies of the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            up_ready_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s != ST_EMPTY);
            up_ready_r  <= (state_nxt_s != ST_FULL);
        end
    end

    // Next-state logic: occupancy moves up on accept-only and down on drain-only.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (in_s) begin
                    state_nxt_s = ST_ONE;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_s && !out_s) begin
                    state_nxt_s = ST_FULL;
                end else if (!in_s && out_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_ONE;
                end
            end
            ST_FULL: begin
                if (out_s) begin
                    state_nxt_s = ST_ONE;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // Output decode: the payload-register load enables for this cycle.
    always_comb begin
        load_out_in_s   = 1'b0;
        load_out_skid_s = 1'b0;
        load_skid_s     = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                load_out_in_s = in_s;
            end
            ST_ONE: begin
                load_out_in_s = in_s & out_s;
                load_skid_s   = in_s & ~out_s;
            end
            ST_FULL: begin
                load_out_skid_s = out_s;
            end
            default: begin
                load_out_in_s   = 1'b0;
                load_out_skid_s = 1'b0;
                load_skid_s     = 1'b0;
            end
        endcase
    end

    // Payload registers: they change only when a beat is accepted, so a pending beat holds steady.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_payload_r  <= {Width{1'b0}};
            skid_payload_r <= {Width{1'b0}};
        end else begin
            if (load_out_in_s) begin
                out_payload_r <= up_payload;
            end else if (load_out_skid_s) begin
                out_payload_r <= skid_payload_r;
            end else begin
                out_payload_r <= out_payload_r;
            end
            if (load_skid_s) begin
                skid_payload_r <= up_payload;
            end else begin
                skid_payload_r <= skid_payload_r;
            end
        end
    end

endmodule

// Top level: five independent channel slices between the manager and the subordinate.
module axi_register_slice #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 20,
    parameter int IdWidth      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    // AW from manager
    input  logic [IdWidth-1:0]        s_axi_awid,
    input  logic [AddressWidth-1:0]   s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_awlock,
    input  logic [3:0]                s_axi_awcache,
    input  logic [2:0]                s_axi_awprot,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    // W from manager
    input  logic [DataWidth-1:0]      s_axi_wdata,
    input  logic [DataWidth/8-1:0]    s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    // B to manager
    output logic [IdWidth-1:0]        s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    // AR from manager
    input  logic [IdWidth-1:0]        s_axi_arid,
    input  logic [AddressWidth-1:0]   s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arlock,
    input  logic [3:0]                s_axi_arcache,
    input  logic [2:0]                s_axi_arprot,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    // R to manager
    output logic [IdWidth-1:0]        s_axi_rid,
    output logic [DataWidth-1:0]      s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    // AW to subordinate
    output logic [IdWidth-1:0]        m_axi_awid,
    output logic [AddressWidth-1:0]   m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awlock,
    output logic [3:0]                m_axi_awcache,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    // W to subordinate
    output logic [DataWidth-1:0]      m_axi_wdata,
    output logic [DataWidth/8-1:0]    m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    // B from subordinate
    input  logic [IdWidth-1:0]        m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    // AR to subordinate
    output logic [IdWidth-1:0]        m_axi_arid,
    output logic [AddressWidth-1:0]   m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    // R from subordinate
    input  logic [IdWidth-1:0]        m_axi_rid,
    input  logic [DataWidth-1:0]      m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int StrbWidth = DataWidth / 8;
    localparam int AxWidth   = IdWidth + AddressWidth + 8 + 3 + 2 + 1 + 4 + 3;
    localparam int WWidth    = DataWidth + StrbWidth + 1;

    logic [AxWidth-1:0] aw_up_s;
    logic [AxWidth-1:0] aw_dn_s;
    logic [WWidth-1:0]  w_up_s;
    logic [WWidth-1:0]  w_dn_s;
    logic [AxWidth-1:0] ar_up_s;
    logic [AxWidth-1:0] ar_dn_s;

    assign aw_up_s = {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize,
                      s_axi_awburst, s_axi_awlock, s_axi_awcache, s_axi_awprot};
    assign {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
            m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot} = aw_dn_s;

    assign w_up_s = {s_axi_wdata, s_axi_wstrb, s_axi_wlast};
    assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast} = w_dn_s;

    assign ar_up_s = {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize,
                      s_axi_arburst, s_axi_arlock, s_axi_arcache, s_axi_arprot};
    assign {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
            m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot} = ar_dn_s;

    axi_register_slice_stage #(.Width(AxWidth)) u_aw (
        .clk        (clk),
        .rst        (rst),
        .up_payload (aw_up_s),
        .up_valid   (s_axi_awvalid),
        .up_ready   (s_axi_awready),
        .dn_payload (aw_dn_s),
        .dn_valid   (m_axi_awvalid),
        .dn_ready   (m_axi_awready)
    );

    axi_register_slice_stage #(.Width(WWidth)) u_w (
        .clk        (clk),
        .rst        (rst),
        .up_payload (w_up_s),
        .up_valid   (s_axi_wvalid),
        .up_ready   (s_axi_wready),
        .dn_payload (w_dn_s),
        .dn_valid   (m_axi_wvalid),
        .dn_ready   (m_axi_wready)
    );

    axi_register_slice_stage #(.Width(AxWidth)) u_ar (
        .clk        (clk),
        .rst        (rst),
        .up_payload (ar_up_s),
        .up_valid   (s_axi_arvalid),
        .up_ready   (s_axi_arready),
        .dn_payload (ar_dn_s),
        .dn_valid   (m_axi_arvalid),
        .dn_ready   (m_axi_arready)
    );

`ifdef AXI_REGISTER_SLICE_RESP_BYPASS_EN
    // Response channels pass straight through with zero latency.
    assign s_axi_bid    = m_axi_bid;
    assign s_axi_bresp  = m_axi_bresp;
    assign s_axi_bvalid = m_axi_bvalid;
    assign m_axi_bready = s_axi_bready;

    assign s_axi_rid    = m_axi_rid;
    assign s_axi_rdata  = m_axi_rdata;
    assign s_axi_rresp  = m_axi_rresp;
    assign s_axi_rlast  = m_axi_rlast;
    assign s_axi_rvalid = m_axi_rvalid;
    assign m_axi_rready = s_axi_rready;
`else
    localparam int BWidth = IdWidth + 2;
    localparam int RWidth = IdWidth + DataWidth + 2 + 1;

    logic [BWidth-1:0] b_up_s;
    logic [BWidth-1:0] b_dn_s;
    logic [RWidth-1:0] r_up_s;
    logic [RWidth-1:0] r_dn_s;

    assign b_up_s = {m_axi_bid, m_axi_bresp};
    assign {s_axi_bid, s_axi_bresp} = b_dn_s;

    assign r_up_s = {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast};
    assign {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast} = r_dn_s;

    axi_register_slice_stage #(.Width(BWidth)) u_b (
        .clk        (clk),
        .rst        (rst),
        .up_payload (b_up_s),
        .up_valid   (m_axi_bvalid),
        .up_ready   (m_axi_bready),
        .dn_payload (b_dn_s),
        .dn_valid   (s_axi_bvalid),
        .dn_ready   (s_axi_bready)
    );

    axi_register_slice_stage #(.Width(RWidth)) u_r (
        .clk        (clk),
        .rst        (rst),
        .up_payload (r_up_s),
        .up_valid   (m_axi_rvalid),
        .up_ready   (m_axi_rready),
        .dn_payload (r_dn_s),
        .dn_valid   (s_axi_rvalid),
        .dn_ready   (s_axi_rready)
    );
`endif

endmodule

// File: tb/tb_axi_register_slice.sv
// Directed testbench for axi_register_slice. Inputs are driven and outputs
// sampled on the falling clock edge. Every output is registered in the default
// build, so a sample taken at a falling edge shows the result of the preceding
// rising edge.
`timescale 1ns/1ps
module tb_axi_register_slice;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_axi_awid;   logic [19:0] s_axi_awaddr; logic [7:0] s_axi_awlen;
    logic [2:0]  s_axi_awsize; logic [1:0]  s_axi_awburst; logic s_axi_awlock;
    logic [3:0]  s_axi_awcache; logic [2:0] s_axi_awprot; logic s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_wdata;  logic [3:0] s_axi_wstrb; logic s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [7:0]  s_axi_bid;    logic [1:0] s_axi_bresp; logic s_axi_bvalid, s_axi_bready;
    logic [7:0]  s_axi_arid;   logic [19:0] s_axi_araddr; logic [7:0] s_axi_arlen;
    logic [2:0]  s_axi_arsize; logic [1:0]  s_axi_arburst; logic s_axi_arlock;
    logic [3:0]  s_axi_arcache; logic [2:0] s_axi_arprot; logic s_axi_arvalid, s_axi_arready;
    logic [7:0]  s_axi_rid;    logic [31:0] s_axi_rdata; logic [1:0] s_axi_rresp;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
    logic [7:0]  m_axi_awid;   logic [19:0] m_axi_awaddr; logic [7:0] m_axi_awlen;
    logic [2:0]  m_axi_awsize; logic [1:0]  m_axi_awburst; logic m_axi_awlock;
    logic [3:0]  m_axi_awcache; logic [2:0] m_axi_awprot; logic m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_wdata;  logic [3:0] m_axi_wstrb; logic m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [7:0]  m_axi_bid;    logic [1:0] m_axi_bresp; logic m_axi_bvalid, m_axi_bready;
    logic [7:0]  m_axi_arid;   logic [19:0] m_axi_araddr; logic [7:0] m_axi_arlen;
    logic [2:0]  m_axi_arsize; logic [1:0]  m_axi_arburst; logic m_axi_arlock;
    logic [3:0]  m_axi_arcache; logic [2:0] m_axi_arprot; logic m_axi_arvalid, m_axi_arready;
    logic [7:0]  m_axi_rid;    logic [31:0] m_axi_rdata; logic [1:0] m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi_register_slice #(.DataWidth(32), .AddressWidth(20), .IdWidth(8)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    task automatic test_reset;
        logic [9:0] vr;
        rst = 1'b1;
        s_axi_awvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vr = {s_axi_awready, s_axi_wready, s_axi_arready, m_axi_bready, m_axi_rready,
                  m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, s_axi_bvalid, s_axi_rvalid};
            checks++;
            if (vr !== 10'b0) begin
                errors++; $display("FAIL reset_valid_ready cycle %0d got=%b exp=%b", i, vr, 10'b0);
            end
            checks++;
            if ({m_axi_awaddr, m_axi_wdata} !== 52'h0) begin
                errors++; $display("FAIL reset_payload got=%h exp=0", {m_axi_awaddr, m_axi_wdata});
            end
        end
        rst = 1'b0;
        s_axi_awaddr = 20'h00ABC;
        s_axi_awid = 8'h5A;
        @(negedge clk);
        checks++;
        if ({s_axi_awready, m_axi_awvalid} !== 2'b10) begin
            errors++; $display("FAIL release_awready got=%b exp=%b", {s_axi_awready, m_axi_awvalid}, 2'b10);
        end
        @(negedge clk);
        checks++;
        if ({m_axi_awvalid, m_axi_awaddr, m_axi_awid} !== {1'b1, 20'h00ABC, 8'h5A}) begin
            errors++; $display("FAIL first_aw got=%h exp=%h", {m_axi_awvalid, m_axi_awaddr, m_axi_awid},
                               {1'b1, 20'h00ABC, 8'h5A});
        end
        s_axi_awvalid = 1'b0;
        m_axi_awready = 1'b1;
        @(negedge clk);
        checks++;
        if (m_axi_awvalid !== 1'b0) begin
            errors++; $display("FAIL first_aw_drain got=%b exp=0", m_axi_awvalid);
        end
    endtask

    task automatic test_stream_write;
        logic [31:0] wbeat [4];
        wbeat[0] = 32'h11111111; wbeat[1] = 32'h22222222;
        wbeat[2] = 32'h33333333; wbeat[3] = 32'h44444444;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        s_axi_awvalid = 1'b1; s_axi_awid = 8'h3C; s_axi_awaddr = 20'h00100;
        s_axi_awlen = 8'd3; s_axi_awsize = 3'd2; s_axi_awburst = 2'd1;
        s_axi_wvalid = 1'b1; s_axi_wdata = wbeat[0]; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if ({m_axi_awvalid, m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst}
                    !== {1'b1, 8'h3C, 20'h00100, 8'd3, 3'd2, 2'd1}) begin
                    errors++; $display("FAIL stream_aw got=%h addr=%h len=%0d", m_axi_awvalid, m_axi_awaddr, m_axi_awlen);
                end
            end else begin
                checks++;
                if (m_axi_awvalid !== 1'b0) begin
                    errors++; $display("FAIL stream_aw_once beat %0d got=%b exp=0", i, m_axi_awvalid);
                end
            end
            checks++;
            if ({m_axi_wvalid, m_axi_wdata, m_axi_wlast, s_axi_wready}
                !== {1'b1, wbeat[i], ((i == 3) ? 1'b1 : 1'b0), 1'b1}) begin
                errors++; $display("FAIL stream_w beat %0d got v=%b d=%h l=%b rdy=%b exp d=%h", i,
                                   m_axi_wvalid, m_axi_wdata, m_axi_wlast, s_axi_wready, wbeat[i]);
            end
            s_axi_awvalid = 1'b0;
            if (i < 3) begin
                s_axi_wdata = wbeat[i + 1];
                s_axi_wlast = (i == 2) ? 1'b1 : 1'b0;
            end else begin
                s_axi_wvalid = 1'b0;
                s_axi_wlast  = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (m_axi_wvalid !== 1'b0) begin
            errors++; $display("FAIL stream_w_end got=%b exp=0", m_axi_wvalid);
        end
        s_axi_bready = 1'b1;
        m_axi_bvalid = 1'b1; m_axi_bid = 8'h3C; m_axi_bresp = 2'd0;
`ifdef AXI_REGISTER_SLICE_RESP_BYPASS_EN
        #1;
`else
        @(negedge clk);
`endif
        checks++;
        if ({s_axi_bvalid, s_axi_bid, s_axi_bresp} !== {1'b1, 8'h3C, 2'd0}) begin
            errors++; $display("FAIL stream_b got v=%b id=%h resp=%0d exp id=3c resp=0",
                               s_axi_bvalid, s_axi_bid, s_axi_bresp);
        end
        m_axi_bvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (s_axi_bvalid !== 1'b0) begin
            errors++; $display("FAIL stream_b_once got=%b exp=0", s_axi_bvalid);
        end
    endtask

`ifndef AXI_REGISTER_SLICE_RESP_BYPASS_EN
    task automatic test_backpressure;
        logic [31:0] rbeat [4];
        int sent = 0;
        int rcvd = 0;
        rbeat[0] = 32'hA0A0A0A0; rbeat[1] = 32'hA1A1A1A1;
        rbeat[2] = 32'hA2A2A2A2; rbeat[3] = 32'hA3A3A3A3;
        m_axi_arready = 1'b1;
        s_axi_arvalid = 1'b1; s_axi_arid = 8'h21; s_axi_araddr = 20'h00200; s_axi_arlen = 8'd3;
        #1;
        checks++;
        if (m_axi_arvalid !== 1'b0) begin
            errors++; $display("FAIL ar_latency_early got=%b exp=0", m_axi_arvalid);
        end
        @(negedge clk);
        checks++;
        if ({m_axi_arvalid, m_axi_arid, m_axi_araddr, m_axi_arlen} !== {1'b1, 8'h21, 20'h00200, 8'd3}) begin
            errors++; $display("FAIL ar_fwd got v=%b addr=%h exp addr=00200", m_axi_arvalid, m_axi_araddr);
        end
        s_axi_arvalid = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            m_axi_rvalid = (sent < 4) ? 1'b1 : 1'b0;
            m_axi_rdata  = rbeat[(sent < 4) ? sent : 3];
            m_axi_rlast  = (sent == 3) ? 1'b1 : 1'b0;
            m_axi_rid    = 8'h21;
            m_axi_rresp  = 2'd0;
            s_axi_rready = (c >= 6) ? 1'b1 : 1'b0;
            if (c == 1) begin
                checks++;
                if (m_axi_rready !== 1'b1) begin
                    errors++; $display("FAIL bp_ready_before_full got=%b exp=1", m_axi_rready);
                end
            end
            if (c >= 2 && c <= 5) begin
                checks++;
                if ({m_axi_rready, s_axi_rvalid, s_axi_rdata, 3'(sent)} !== {1'b0, 1'b1, rbeat[0], 3'd2}) begin
                    errors++; $display("FAIL bp_stall cycle %0d got rdy=%b v=%b d=%h sent=%0d exp rdy=0 d=%h sent=2",
                                       c, m_axi_rready, s_axi_rvalid, s_axi_rdata, sent, rbeat[0]);
                end
            end
            if (m_axi_rvalid && m_axi_rready) begin
                sent++;
            end
            if (s_axi_rvalid && s_axi_rready) begin
                checks++;
                if (rcvd >= 4) begin
                    errors++; $display("FAIL bp_extra_beat got=%h exp=none", s_axi_rdata);
                end else if ({s_axi_rdata, s_axi_rlast, s_axi_rid} !== {rbeat[rcvd], ((rcvd == 3) ? 1'b1 : 1'b0), 8'h21}) begin
                    errors++; $display("FAIL bp_order beat %0d got=%h last=%b exp=%h", rcvd,
                                       s_axi_rdata, s_axi_rlast, rbeat[rcvd]);
                end
                rcvd++;
            end
        end
        checks++;
        if ({rcvd[3:0], s_axi_rvalid} !== {4'd4, 1'b0}) begin
            errors++; $display("FAIL bp_count got=%0d beats exp=4", rcvd);
        end
        s_axi_rready = 1'b0;
    endtask
`endif

    task automatic test_stability;
        m_axi_awready = 1'b0;
        s_axi_awvalid = 1'b1; s_axi_awid = 8'h77; s_axi_awaddr = 20'h00F0F; s_axi_awlen = 8'd7;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checks++;
            if ({m_axi_awvalid, m_axi_awid, m_axi_awaddr, m_axi_awlen} !== {1'b1, 8'h77, 20'h00F0F, 8'd7}) begin
                errors++; $display("FAIL stable_aw cycle %0d got addr=%h id=%h len=%0d exp addr=00f0f id=77 len=7",
                                   i, m_axi_awaddr, m_axi_awid, m_axi_awlen);
            end
            if (i == 1) begin
                s_axi_awid = 8'h78; s_axi_awaddr = 20'h00AAA; s_axi_awlen = 8'd1;
            end else begin
                s_axi_awvalid = 1'b0;
                checks++;
                if (s_axi_awready !== 1'b0) begin
                    errors++; $display("FAIL stable_full_ready cycle %0d got=%b exp=0", i, s_axi_awready);
                end
            end
        end
        m_axi_awready = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_axi_awvalid, m_axi_awaddr, m_axi_awid, s_axi_awready} !== {1'b1, 20'h00AAA, 8'h78, 1'b1}) begin
            errors++; $display("FAIL skid_move got addr=%h id=%h rdy=%b exp addr=00aaa id=78 rdy=1",
                               m_axi_awaddr, m_axi_awid, s_axi_awready);
        end
        @(negedge clk);
        checks++;
        if (m_axi_awvalid !== 1'b0) begin
            errors++; $display("FAIL skid_drain got=%b exp=0", m_axi_awvalid);
        end
    endtask

    task automatic test_midburst_reset;
        m_axi_wready = 1'b0;
        s_axi_wvalid = 1'b1; s_axi_wdata = 32'hDEAD0001; s_axi_wlast = 1'b0;
        @(negedge clk);
        s_axi_wdata = 32'hDEAD0002;
        @(negedge clk);
        checks++;
        if ({m_axi_wvalid, m_axi_wdata, s_axi_wready} !== {1'b1, 32'hDEAD0001, 1'b0}) begin
            errors++; $display("FAIL midrst_full got d=%h rdy=%b exp d=dead0001 rdy=0", m_axi_wdata, s_axi_wready);
        end
        rst = 1'b1;
        s_axi_wvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_axi_wvalid, m_axi_awvalid, m_axi_arvalid, s_axi_bvalid, s_axi_rvalid, s_axi_wready} !== 6'b0) begin
            errors++; $display("FAIL midrst_clear got=%b exp=000000",
                               {m_axi_wvalid, m_axi_awvalid, m_axi_arvalid, s_axi_bvalid, s_axi_rvalid, s_axi_wready});
        end
        rst = 1'b0;
        m_axi_wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({m_axi_wvalid, m_axi_wdata} !== {1'b0, 32'h0}) begin
                errors++; $display("FAIL midrst_stale cycle %0d got v=%b d=%h exp v=0 d=0", i, m_axi_wvalid, m_axi_wdata);
            end
        end
    endtask

`ifdef AXI_REGISTER_SLICE_RESP_BYPASS_EN
    task automatic test_bypass;
        m_axi_arready = 1'b1;
        s_axi_rready = 1'b1;
        #1;
        checks++;
        if (m_axi_rready !== 1'b1) begin
            errors++; $display("FAIL bypass_rready_hi got=%b exp=1", m_axi_rready);
        end
        s_axi_rready = 1'b0;
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'h5555AAAA;
        #1;
        checks++;
        if ({m_axi_rready, s_axi_rvalid, s_axi_rdata} !== {1'b0, 1'b1, 32'h5555AAAA}) begin
            errors++; $display("FAIL bypass_r_wire got rdy=%b v=%b d=%h exp rdy=0 v=1 d=5555aaaa",
                               m_axi_rready, s_axi_rvalid, s_axi_rdata);
        end
        m_axi_rvalid = 1'b0;
        @(negedge clk);
        s_axi_arvalid = 1'b1; s_axi_araddr = 20'h00200;
        #1;
        checks++;
        if (m_axi_arvalid !== 1'b0) begin
            errors++; $display("FAIL bypass_ar_early got=%b exp=0", m_axi_arvalid);
        end
        @(negedge clk);
        checks++;
        if ({m_axi_arvalid, m_axi_araddr} !== {1'b1, 20'h00200}) begin
            errors++; $display("FAIL bypass_ar_latency got v=%b a=%h exp v=1 a=00200", m_axi_arvalid, m_axi_araddr);
        end
        s_axi_arvalid = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        rst = 1'b1;
        s_axi_awid = 8'h0; s_axi_awaddr = 20'h0; s_axi_awlen = 8'h0; s_axi_awsize = 3'd0;
        s_axi_awburst = 2'd0; s_axi_awlock = 1'b0; s_axi_awcache = 4'h0; s_axi_awprot = 3'd0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata = 32'h0; s_axi_wstrb = 4'h0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_arid = 8'h0; s_axi_araddr = 20'h0; s_axi_arlen = 8'h0; s_axi_arsize = 3'd0;
        s_axi_arburst = 2'd0; s_axi_arlock = 1'b0; s_axi_arcache = 4'h0; s_axi_arprot = 3'd0;
        s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bid = 8'h0; m_axi_bresp = 2'd0; m_axi_bvalid = 1'b0;
        m_axi_rid = 8'h0; m_axi_rdata = 32'h0; m_axi_rresp = 2'd0; m_axi_rlast = 1'b0;
        m_axi_rvalid = 1'b0;

        test_reset();
        test_stream_write();
`ifndef AXI_REGISTER_SLICE_RESP_BYPASS_EN
        test_backpressure();
`endif
        test_stability();
        test_midburst_reset();
`ifdef AXI_REGISTER_SLICE_RESP_BYPASS_EN
        test_bypass();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
